// File: rtl/ltpi_pkg.sv
// Shared LTPI constants: frame-index width limits, the default fill
// value for the remote GPIO vector, and an index-width helper.
package ltpi_pkg;

    localparam int   LTPI_IDX_W_MIN        = 1;
    localparam int   LTPI_IDX_W_MAX        = 8;
    localparam logic LTPI_RX_DEFAULT_FILL  = 1'b0;

    // Frame-index width for a rotation of num_frames slots (never below 1 bit)
    function automatic int ltpi_idx_width(input int num_frames);
        int w;
        w = $clog2(num_frames);
        if (w < LTPI_IDX_W_MIN) begin
            w = LTPI_IDX_W_MIN;
        end
        return w;
    endfunction

endpackage

// File: rtl/ltpi_nl_gpio_rx_assembler.sv
// Reassembles received GPIO slots into a coherent remote vector.
// Tracks the expected slot index, keeps a shadow of the slots and commits
// the shadow only after an unbroken rotation starting at index 0.
module ltpi_nl_gpio_rx_assembler
    import ltpi_pkg::*;
#(
    parameter int                    NL_GPIO_NB     = 64,
    parameter int                    BITS_PER_FRAME = 8,
    parameter logic [NL_GPIO_NB-1:0] RX_DEFAULT     = '0,
    parameter int                    NUM_FRAMES     = NL_GPIO_NB / BITS_PER_FRAME,
    parameter int                    IDX_W          = ltpi_idx_width(NUM_FRAMES)
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      link_up,
    input  logic                      rx_valid,
    input  logic [IDX_W-1:0]          rx_frame_idx,
    input  logic [BITS_PER_FRAME-1:0] rx_gpio_bits,
    output logic [NL_GPIO_NB-1:0]     nl_gpio_out,
    output logic                      rx_sync,
    output logic                      rx_idx_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FRAMES - 1);
    localparam logic [IDX_W:0]   NF_EXT   = (IDX_W + 1)'(NUM_FRAMES);

    logic [IDX_W-1:0]          expected_reg;
    logic                      seq_valid_reg;
    logic [BITS_PER_FRAME-1:0] shadow_reg [NUM_FRAMES];
    logic [NL_GPIO_NB-1:0]     out_reg;
    logic                      sync_reg;
    logic                      idx_err_reg;

    logic                      idx_in_range;
    logic                      idx_match;
    logic                      idx_first;
    logic                      idx_last;
    logic                      commit;
    logic [IDX_W-1:0]          expected_next;
    logic [NL_GPIO_NB-1:0]     commit_vec;

    // Commit image: the shadow with the incoming slot merged in
    genvar gi;
    generate
        for (gi = 0; gi < NUM_FRAMES; gi++) begin : g_commit
            assign commit_vec[gi*BITS_PER_FRAME +: BITS_PER_FRAME] =
                (rx_frame_idx == IDX_W'(gi)) ? rx_gpio_bits : shadow_reg[gi];
        end
    endgenerate

    // Classify the incoming index and decide whether this frame completes a rotation
    always_comb begin
        idx_in_range  = ({1'b0, rx_frame_idx} < NF_EXT);
        idx_match     = idx_in_range && (rx_frame_idx == expected_reg);
        idx_first     = (rx_frame_idx == '0);
        idx_last      = (rx_frame_idx == LAST_IDX);
        expected_next = (!idx_in_range || idx_last) ? '0 : rx_frame_idx + IDX_W'(1);
        commit        = rx_valid && idx_match && idx_last && (seq_valid_reg || idx_first);
    end

    // Sequence tracking, shadow capture and commit; link loss discards sync state
    always_ff @(posedge clk) begin
        if (reset) begin
            expected_reg  <= '0;
            seq_valid_reg <= 1'b0;
            out_reg       <= RX_DEFAULT;
            sync_reg      <= 1'b0;
            idx_err_reg   <= 1'b0;
            for (int i = 0; i < NUM_FRAMES; i++) begin
                shadow_reg[i] <= '0;
            end
        end else begin
            idx_err_reg <= 1'b0;
            if (!link_up) begin
                expected_reg  <= '0;
                seq_valid_reg <= 1'b0;
                out_reg       <= RX_DEFAULT;
                sync_reg      <= 1'b0;
            end else if (rx_valid) begin
                expected_reg <= expected_next;
                if (idx_in_range) begin
                    shadow_reg[rx_frame_idx] <= rx_gpio_bits;
                end
                if (!idx_match) begin
                    idx_err_reg   <= 1'b1;
                    seq_valid_reg <= 1'b0;
                end else if (idx_first) begin
                    seq_valid_reg <= 1'b1;
                end
                if (commit) begin
                    out_reg  <= commit_vec;
                    sync_reg <= 1'b1;
                end
            end
        end
    end

    assign nl_gpio_out = out_reg;
    assign rx_sync     = sync_reg;
    assign rx_idx_err  = idx_err_reg;

endmodule

// File: rtl/ltpi_nl_gpio_mux.sv
// Normal-latency GPIO multiplexer: slices the local GPIO vector into
// indexed per-frame slots for the framer and reassembles remote slots.
module ltpi_nl_gpio_mux
    import ltpi_pkg::*;
#(
    parameter int                    NL_GPIO_NB     = 64,
    parameter int                    BITS_PER_FRAME = 8,
    parameter logic [NL_GPIO_NB-1:0] RX_DEFAULT     = {NL_GPIO_NB{LTPI_RX_DEFAULT_FILL}},
    localparam int                   NUM_FRAMES     = NL_GPIO_NB / BITS_PER_FRAME,
    localparam int                   IDX_W          = ltpi_idx_width(NUM_FRAMES)
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      link_up,
    input  logic [NL_GPIO_NB-1:0]     nl_gpio_in,
    input  logic                      tx_frame_req,
    output logic                      tx_valid,
    output logic [IDX_W-1:0]          tx_frame_idx,
    output logic [BITS_PER_FRAME-1:0] tx_gpio_bits,
    input  logic                      rx_valid,
    input  logic [IDX_W-1:0]          rx_frame_idx,
    input  logic [BITS_PER_FRAME-1:0] rx_gpio_bits,
    output logic [NL_GPIO_NB-1:0]     nl_gpio_out,
    output logic                      rx_sync,
    output logic                      rx_idx_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FRAMES - 1);

    logic [IDX_W-1:0]          tx_cnt_reg;
    logic [NL_GPIO_NB-1:0]     tx_shadow_reg;
    logic                      tx_valid_reg;
    logic [IDX_W-1:0]          tx_idx_reg;
    logic [BITS_PER_FRAME-1:0] tx_bits_reg;
    logic [BITS_PER_FRAME-1:0] shadow_slot [NUM_FRAMES];

    // View the TX snapshot as an array of slots
    genvar gi;
    generate
        for (gi = 0; gi < NUM_FRAMES; gi++) begin : g_tx_slot
            assign shadow_slot[gi] = tx_shadow_reg[gi*BITS_PER_FRAME +: BITS_PER_FRAME];
        end
    endgenerate

    // TX slicer: snapshot at slot 0 so one rotation always carries one coherent vector
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_cnt_reg    <= '0;
            tx_shadow_reg <= '0;
            tx_valid_reg  <= 1'b0;
            tx_idx_reg    <= '0;
            tx_bits_reg   <= '0;
        end else if (!link_up) begin
            tx_cnt_reg   <= '0;
            tx_valid_reg <= 1'b0;
        end else if (tx_frame_req) begin
            tx_valid_reg <= 1'b1;
            tx_idx_reg   <= tx_cnt_reg;
            if (tx_cnt_reg == '0) begin
                tx_shadow_reg <= nl_gpio_in;
                tx_bits_reg   <= nl_gpio_in[BITS_PER_FRAME-1:0];
            end else begin
                tx_bits_reg   <= shadow_slot[tx_cnt_reg];
            end
            tx_cnt_reg <= (tx_cnt_reg == LAST_IDX) ? '0 : tx_cnt_reg + IDX_W'(1);
        end else begin
            tx_valid_reg <= 1'b0;
        end
    end

    assign tx_valid     = tx_valid_reg;
    assign tx_frame_idx = tx_idx_reg;
    assign tx_gpio_bits = tx_bits_reg;

    ltpi_nl_gpio_rx_assembler #(
        .NL_GPIO_NB     (NL_GPIO_NB),
        .BITS_PER_FRAME (BITS_PER_FRAME),
        .RX_DEFAULT     (RX_DEFAULT),
        .NUM_FRAMES     (NUM_FRAMES),
        .IDX_W          (IDX_W)
    ) u_rx_assembler (
        .clk          (clk),
        .reset        (reset),
        .link_up      (link_up),
        .rx_valid     (rx_valid),
        .rx_frame_idx (rx_frame_idx),
        .rx_gpio_bits (rx_gpio_bits),
        .nl_gpio_out  (nl_gpio_out),
        .rx_sync      (rx_sync),
        .rx_idx_err   (rx_idx_err)
    );

endmodule

// File: tb/tb_ltpi_nl_gpio_mux.sv
// Bench for ltpi_nl_gpio_mux: a 64/8 instance (all-ones RX default) and a
// 24/8 instance (three frames), checked every cycle against a frame-level model.
module tb_ltpi_nl_gpio_mux;

    localparam logic [63:0] DFLT_A = '1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic        a_link, a_req, a_rx_valid;
    logic [63:0] a_in;
    logic        a_tx_valid;
    logic [2:0]  a_tx_idx, a_rx_idx;
    logic [7:0]  a_tx_bits, a_rx_bits;
    logic [63:0] a_out;
    logic        a_sync, a_err;

    logic        b_link, b_req, b_rx_valid;
    logic [23:0] b_in;
    logic        b_tx_valid;
    logic [1:0]  b_tx_idx, b_rx_idx;
    logic [7:0]  b_tx_bits, b_rx_bits;
    logic [23:0] b_out;
    logic        b_sync, b_err;

    ltpi_nl_gpio_mux #(.NL_GPIO_NB(64), .BITS_PER_FRAME(8), .RX_DEFAULT(DFLT_A)) dut_a (
        .clk(clk), .reset(reset), .link_up(a_link), .nl_gpio_in(a_in),
        .tx_frame_req(a_req), .tx_valid(a_tx_valid), .tx_frame_idx(a_tx_idx),
        .tx_gpio_bits(a_tx_bits), .rx_valid(a_rx_valid), .rx_frame_idx(a_rx_idx),
        .rx_gpio_bits(a_rx_bits), .nl_gpio_out(a_out), .rx_sync(a_sync),
        .rx_idx_err(a_err)
    );

    ltpi_nl_gpio_mux #(.NL_GPIO_NB(24), .BITS_PER_FRAME(8)) dut_b (
        .clk(clk), .reset(reset), .link_up(b_link), .nl_gpio_in(b_in),
        .tx_frame_req(b_req), .tx_valid(b_tx_valid), .tx_frame_idx(b_tx_idx),
        .tx_gpio_bits(b_tx_bits), .rx_valid(b_rx_valid), .rx_frame_idx(b_rx_idx),
        .rx_gpio_bits(b_rx_bits), .nl_gpio_out(b_out), .rx_sync(b_sync),
        .rx_idx_err(b_err)
    );

    // Frame-level model state plus the outputs it predicts after the next edge
    typedef struct packed {
        int          cnt;
        logic [63:0] snap;
        int          exp_idx;
        bit          run_ok;
        logic [63:0] asm_v;
        logic        tx_valid;
        int          tx_idx;
        logic [7:0]  tx_bits;
        logic [63:0] out;
        logic        sync;
        logic        err;
    } mstate_t;

    mstate_t sa, sb;
    int  checks = 0;
    int  errors = 0;
    bit  chk_en = 1'b0;

    function automatic mstate_t model_step(input mstate_t s, input int nf, input logic [63:0] dflt,
                                           input bit rst, input bit link, input bit req,
                                           input logic [63:0] gin, input bit rv, input int ridx,
                                           input logic [7:0] rbits);
        mstate_t n;
        n = s;
        n.err = 1'b0;
        if (rst) begin
            n.cnt = 0; n.tx_valid = 1'b0; n.tx_idx = 0; n.tx_bits = 8'h00;
            n.exp_idx = 0; n.run_ok = 1'b0; n.out = dflt; n.sync = 1'b0;
            return n;
        end
        // transmit side: one slot per request, fresh snapshot at the start of a rotation
        n.tx_valid = 1'b0;
        if (!link) begin
            n.cnt = 0;
        end else if (req) begin
            if (s.cnt == 0) n.snap = gin;
            n.tx_valid = 1'b1;
            n.tx_idx   = s.cnt;
            n.tx_bits  = 8'(n.snap >> (8 * s.cnt));
            n.cnt      = (s.cnt + 1) % nf;
        end
        // receive side: a rotation is good only if it began at 0 and saw no error
        if (!link) begin
            n.exp_idx = 0; n.run_ok = 1'b0; n.out = dflt; n.sync = 1'b0;
        end else if (rv) begin
            if (ridx >= nf) begin
                n.err = 1'b1; n.run_ok = 1'b0; n.exp_idx = 0;
            end else begin
                n.asm_v = (n.asm_v & ~(64'hFF << (8 * ridx))) | (64'(rbits) << (8 * ridx));
                if (ridx != s.exp_idx) begin
                    n.err = 1'b1; n.run_ok = 1'b0;
                end else if (ridx == 0) begin
                    n.run_ok = 1'b1;
                end
                n.exp_idx = (ridx + 1) % nf;
                if (ridx == s.exp_idx && ridx == nf - 1 && n.run_ok) begin
                    n.out  = n.asm_v;
                    n.sync = 1'b1;
                end
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            check("a_tx_valid", 64'(a_tx_valid), 64'(sa.tx_valid));
            check("a_tx_idx",   64'(a_tx_idx),   64'(sa.tx_idx));
            check("a_tx_bits",  64'(a_tx_bits),  64'(sa.tx_bits));
            check("a_out",      a_out,           sa.out);
            check("a_sync",     64'(a_sync),     64'(sa.sync));
            check("a_err",      64'(a_err),      64'(sa.err));
            check("b_tx_valid", 64'(b_tx_valid), 64'(sb.tx_valid));
            check("b_tx_idx",   64'(b_tx_idx),   64'(sb.tx_idx));
            check("b_tx_bits",  64'(b_tx_bits),  64'(sb.tx_bits));
            check("b_out",      64'(b_out),      sb.out & 64'hFF_FFFF);
            check("b_sync",     64'(b_sync),     64'(sb.sync));
            check("b_err",      64'(b_err),      64'(sb.err));
            if (a_tx_valid) $display("t=%0t a tx idx=%0d bits=%h", $time, a_tx_idx, a_tx_bits);
            if (b_tx_valid) $display("t=%0t b tx idx=%0d bits=%h", $time, b_tx_idx, b_tx_bits);
        end
    end

    // One clock: advance the model with the current inputs, then let the DUTs clock
    task automatic tick();
        sa = model_step(sa, 8, DFLT_A, reset, a_link, a_req, a_in,
                        a_rx_valid, int'(a_rx_idx), a_rx_bits);
        sb = model_step(sb, 3, 64'h0, reset, b_link, b_req, 64'(b_in),
                        b_rx_valid, int'(b_rx_idx), b_rx_bits);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rx_a(input int idx, input logic [7:0] bits);
        a_rx_valid = 1'b1; a_rx_idx = 3'(idx); a_rx_bits = bits;
        tick();
        a_rx_valid = 1'b0;
        $display("t=%0t a rx idx=%0d bits=%h out=%h sync=%0b err=%0b", $time, idx, bits, a_out, a_sync, a_err);
    endtask

    task automatic rx_b(input int idx, input logic [7:0] bits);
        b_rx_valid = 1'b1; b_rx_idx = 2'(idx); b_rx_bits = bits;
        tick();
        b_rx_valid = 1'b0;
        $display("t=%0t b rx idx=%0d bits=%h out=%h sync=%0b err=%0b", $time, idx, bits, b_out, b_sync, b_err);
    endtask

    logic [7:0] exp_bytes [8];
    logic [7:0] b_bytes   [3];

    initial begin
        exp_bytes = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        b_bytes   = '{8'hEF, 8'hCD, 8'hAB};
        sa = '0; sb = '0;
        reset = 1'b1;
        a_link = 1'b1; a_req = 1'b0; a_in = '0; a_rx_valid = 1'b0; a_rx_idx = '0; a_rx_bits = '0;
        b_link = 1'b1; b_req = 1'b0; b_in = '0; b_rx_valid = 1'b0; b_rx_idx = '0; b_rx_bits = '0;
        @(negedge clk);
        chk_en = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("reset_a_out",  a_out, 64'hFFFF_FFFF_FFFF_FFFF);
        check("reset_a_sync", 64'(a_sync), 64'h0);
        check("reset_b_out",  64'(b_out), 64'h0);

        // TX slicing of one coherent vector, then snapshot coherence across an input change
        a_in  = 64'h0123_4567_89AB_CDEF;
        a_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("lit_tx_idx",  64'(a_tx_idx),  64'(i));
            check("lit_tx_bits", 64'(a_tx_bits), 64'(exp_bytes[i]));
        end
        tick();
        check("lit_wrap_idx", 64'(a_tx_idx), 64'h0);
        for (int i = 1; i < 4; i++) tick();
        a_in = 64'hFEDC_BA98_7654_3210;
        tick();
        check("lit_old_snap", 64'(a_tx_bits), 64'h67);
        for (int i = 5; i < 8; i++) tick();
        tick();
        check("lit_new_snap", 64'(a_tx_bits), 64'h10);
        a_req = 1'b0;
        tick();

        // RX loopback of a full in-order rotation
        for (int i = 0; i < 7; i++) rx_a(i, exp_bytes[i]);
        check("lit_no_early_commit", a_out, 64'hFFFF_FFFF_FFFF_FFFF);
        rx_a(7, exp_bytes[7]);
        check("lit_commit", a_out, 64'h0123_4567_89AB_CDEF);
        check("lit_sync",   64'(a_sync), 64'h1);

        // Skipped index: error pulse, no commit, then a clean rotation commits
        rx_a(0, 8'h10); rx_a(1, 8'h11); rx_a(3, 8'h13);
        check("lit_idx_err", 64'(a_err), 64'h1);
        for (int i = 4; i < 8; i++) rx_a(i, 8'(8'h10 + i));
        check("lit_err_no_commit", a_out, 64'h0123_4567_89AB_CDEF);
        for (int i = 0; i < 8; i++) rx_a(i, 8'(8'hA0 + i));
        check("lit_recommit", a_out, 64'hA7A6_A5A4_A3A2_A1A0);

        // Link drop mid-rotation, with a request in the same cycle
        a_req = 1'b1;
        tick(); tick();
        rx_a(0, 8'h33); rx_a(1, 8'h34); rx_a(2, 8'h35);
        a_link = 1'b0;
        tick();
        check("lit_linkdown_txv",  64'(a_tx_valid), 64'h0);
        check("lit_linkdown_out",  a_out, 64'hFFFF_FFFF_FFFF_FFFF);
        check("lit_linkdown_sync", 64'(a_sync), 64'h0);
        a_link = 1'b1;
        tick();
        check("lit_reup_idx",  64'(a_tx_idx), 64'h0);
        check("lit_reup_bits", 64'(a_tx_bits), 64'h10);
        a_req = 1'b0;
        for (int i = 3; i < 8; i++) rx_a(i, 8'(8'h40 + i));
        for (int i = 0; i < 8; i++) rx_a(i, 8'(8'h50 + i));
        check("lit_reup_commit", a_out, 64'h5756_5554_5352_5150);

        // Reset in the middle of a rotation: the tail never commits
        for (int i = 0; i < 4; i++) rx_a(i, 8'(8'h60 + i));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("lit_midreset_out", a_out, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 4; i < 8; i++) rx_a(i, 8'(8'h60 + i));
        check("lit_midreset_tail", a_out, 64'hFFFF_FFFF_FFFF_FFFF);

        // Three-frame instance: out-of-range index and a clean 0,1,2 commit
        b_in  = 24'hAB_CDEF;
        b_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lit_b_tx_bits", 64'(b_tx_bits), 64'(b_bytes[i]));
        end
        b_req = 1'b0;
        rx_b(3, 8'h99);
        check("lit_b_idx_err", 64'(b_err), 64'h1);
        for (int i = 0; i < 3; i++) rx_b(i, b_bytes[i]);
        check("lit_b_commit", 64'(b_out), 64'hAB_CDEF);
        check("lit_b_sync",   64'(b_sync), 64'h1);
        tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
